// File: rtl/cache_mem_arbiter_if.sv
// rtl/cache_mem_arbiter_if.sv - icache/dcache/memory signal bundle for cache_mem_arbiter
//
// Purpose: groups the icache request/response, dcache request/response and
//          256-bit memory port signals into one interface.
// Modports:
//   master - arbiter view: takes cache requests and memory replies, drives
//            cache responses and memory strobes.
//   slave  - environment view (caches plus memory), the mirror of master.
// Signals:
//   i_read, i_addr / i_rdata, i_resp            icache line read channel
//   d_read, d_write, d_addr, d_wdata /
//   d_rdata, d_resp                             dcache read/writeback channel
//   mem_read, mem_write, mem_addr, mem_wdata /
//   mem_rdata, mem_resp                         shared memory port

interface cache_mem_arbiter_if #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
);
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_resp;

    modport master (
        input  i_read, i_addr,
        output i_rdata, i_resp,
        input  d_read, d_write, d_addr, d_wdata,
        output d_rdata, d_resp,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_resp
    );

    modport slave (
        output i_read, i_addr,
        input  i_rdata, i_resp,
        output d_read, d_write, d_addr, d_wdata,
        input  d_rdata, d_resp,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_resp
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - shares one memory line port between icache and dcache miss paths
//
// Purpose: captures one icache or dcache request, runs it on the memory port,
//          returns the line and a one-cycle resp pulse to the winning side.
//          Ties go round-robin (D_PRIO=0) or always to the dcache (D_PRIO=1).
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - cache_mem_arbiter_if.master (cache channels and memory port)
// All outputs are registered and reset to 0.

module cache_mem_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32,
    parameter int D_PRIO = 0
) (
    input logic                 clk,
    input logic                 rst,
    cache_mem_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MEM_I = 2'd1,
        MEM_D = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q;
    logic              last_grant_q;   // 0 = icache, 1 = dcache
    logic              mem_read_q;
    logic              mem_write_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [LINE_W-1:0] mem_wdata_q;
    logic [LINE_W-1:0] i_rdata_q;
    logic [LINE_W-1:0] d_rdata_q;
    logic              i_resp_q;
    logic              d_resp_q;

    logic i_req;
    logic d_req;
    logic grant_any;
    logic grant_d;

    // Arbitration decision, only consumed in IDLE.
    always_comb begin
        i_req     = bus.i_read;
        d_req     = bus.d_read | bus.d_write;
        grant_any = i_req | d_req;
        if (i_req && d_req) begin
            // Tie: fixed D priority, or the side that did not win last time.
            grant_d = (D_PRIO != 0) || !last_grant_q;
        end else begin
            grant_d = d_req;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            i_resp_q     <= 1'b0;
            d_resp_q     <= 1'b0;
        end else begin
            i_resp_q <= 1'b0;
            d_resp_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_any) begin
                        last_grant_q <= grant_d;
                        if (grant_d) begin
                            mem_addr_q  <= {bus.d_addr[ADDR_W-1:5], 5'b0};
                            mem_wdata_q <= bus.d_wdata;
                            // Read+write together is illegal; the writeback wins.
                            mem_write_q <= bus.d_write;
                            mem_read_q  <= ~bus.d_write;
                            state_q     <= MEM_D;
                        end else begin
                            mem_addr_q  <= {bus.i_addr[ADDR_W-1:5], 5'b0};
                            mem_write_q <= 1'b0;
                            mem_read_q  <= 1'b1;
                            state_q     <= MEM_I;
                        end
                    end
                end
                MEM_I: begin
                    if (bus.mem_resp) begin
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        i_rdata_q   <= bus.mem_rdata;
                        i_resp_q    <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                MEM_D: begin
                    if (bus.mem_resp) begin
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        // A writeback leaves the dcache line register untouched.
                        if (mem_read_q) begin
                            d_rdata_q <= bus.mem_rdata;
                        end
                        d_resp_q    <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    // One dead cycle lets the served side drop its request
                    // before arbitration looks at it again.
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.i_resp    = i_resp_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_resp    = d_resp_q;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - self-checking bench for cache_mem_arbiter

module tb_cache_mem_arbiter;
    localparam logic [255:0] L_A5 = {32{8'hA5}};
    localparam logic [255:0] L_5A = {32{8'h5A}};
    localparam logic [255:0] L_0F = {32{8'h0F}};
    localparam logic [255:0] L_3C = {32{8'h3C}};
    localparam logic [255:0] L_FF = {32{8'hFF}};
    localparam logic [255:0] L_77 = {32{8'h77}};
    localparam logic [255:0] L_C3 = {32{8'hC3}};
    localparam logic [255:0] L_WB = {4{64'h0123_4567_89AB_CDEF}};

    logic clk;
    logic rst;
    logic sel;

    logic         i_read, d_read, d_write, mem_resp;
    logic [31:0]  i_addr, d_addr;
    logic [255:0] d_wdata, mem_rdata;

    logic         o_mem_read, o_mem_write, o_i_resp, o_d_resp;
    logic [31:0]  o_mem_addr;
    logic [255:0] o_mem_wdata, o_i_rdata, o_d_rdata;

    cache_mem_arbiter_if bus0 ();
    cache_mem_arbiter_if bus1 ();

    cache_mem_arbiter #(.LINE_W(256), .ADDR_W(32), .D_PRIO(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    cache_mem_arbiter #(.LINE_W(256), .ADDR_W(32), .D_PRIO(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    assign bus0.i_read = i_read;     assign bus1.i_read = i_read;
    assign bus0.i_addr = i_addr;     assign bus1.i_addr = i_addr;
    assign bus0.d_read = d_read;     assign bus1.d_read = d_read;
    assign bus0.d_write = d_write;   assign bus1.d_write = d_write;
    assign bus0.d_addr = d_addr;     assign bus1.d_addr = d_addr;
    assign bus0.d_wdata = d_wdata;   assign bus1.d_wdata = d_wdata;
    assign bus0.mem_rdata = mem_rdata; assign bus1.mem_rdata = mem_rdata;
    assign bus0.mem_resp = mem_resp; assign bus1.mem_resp = mem_resp;

    always_comb begin
        o_mem_read  = sel ? bus1.mem_read  : bus0.mem_read;
        o_mem_write = sel ? bus1.mem_write : bus0.mem_write;
        o_mem_addr  = sel ? bus1.mem_addr  : bus0.mem_addr;
        o_mem_wdata = sel ? bus1.mem_wdata : bus0.mem_wdata;
        o_i_rdata   = sel ? bus1.i_rdata   : bus0.i_rdata;
        o_i_resp    = sel ? bus1.i_resp    : bus0.i_resp;
        o_d_rdata   = sel ? bus1.d_rdata   : bus0.d_rdata;
        o_d_resp    = sel ? bus1.d_resp    : bus0.d_resp;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cur = -1;

    typedef struct {
        logic         is_i;
        logic         d_rd;
        logic         d_wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
        int           lat;
        logic [255:0] rdata;
        logic         exp_rd;
        logic         exp_wr;
        logic [31:0]  exp_addr;
        logic [255:0] exp_i_rdata;
        logic [255:0] exp_d_rdata;
    } vec_t;

    vec_t vecs[5];
    int   order_q[$];
    int   rise_q[$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): actual %0h required %0h", name, cur, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic int ord_at(input int k);
        return (order_q.size() > k) ? order_q[k] : -1;
    endfunction

    task automatic run_vec(input vec_t v);
        i_read  = v.is_i;
        d_read  = !v.is_i && v.d_rd;
        d_write = !v.is_i && v.d_wr;
        i_addr  = v.addr;
        d_addr  = v.addr;
        d_wdata = v.wdata;
        tick();
        for (int c = 0; c < v.lat; c++) begin
            chk("mem_read", o_mem_read, v.exp_rd);
            chk("mem_write", o_mem_write, v.exp_wr);
            chk("mem_addr", o_mem_addr, v.exp_addr);
            if (v.exp_wr) chk("mem_wdata", o_mem_wdata, v.wdata);
            // Requester inputs change mid-transaction; memory side must not follow.
            i_addr  = ~v.addr;
            d_addr  = ~v.addr;
            d_wdata = ~v.wdata;
            if (c == v.lat - 1) begin
                mem_resp  = 1'b1;
                mem_rdata = v.rdata;
            end
            tick();
        end
        mem_resp = 1'b0;
        chk("i_resp_pulse", o_i_resp, v.is_i);
        chk("d_resp_pulse", o_d_resp, !v.is_i);
        chk("strobe_drop", {o_mem_read, o_mem_write}, 2'b00);
        chk("i_rdata", o_i_rdata, v.exp_i_rdata);
        chk("d_rdata", o_d_rdata, v.exp_d_rdata);
        i_read  = 1'b0;
        d_read  = 1'b0;
        d_write = 1'b0;
        tick();
        chk("resp_one_cycle", {o_i_resp, o_d_resp}, 2'b00);
        tick();
    endtask

    // Requesters hold until their own resp; memory answers after lat strobe cycles.
    task automatic run_order(input logic want_i, input logic want_d, input int lat);
        int   cnt;
        int   need;
        logic busy;
        logic prev;
        cnt  = 0;
        prev = 1'b0;
        need = int'(want_i) + int'(want_d);
        order_q.delete();
        rise_q.delete();
        i_read  = want_i;
        d_read  = want_d;
        d_write = 1'b0;
        i_addr  = 32'h0000_2000;
        d_addr  = 32'h0000_3000;
        for (int cyc = 0; cyc < 100; cyc++) begin
            tick();
            busy = o_mem_read | o_mem_write;
            if (busy && !prev) rise_q.push_back(cyc);
            prev = busy;
            if (o_d_resp) begin order_q.push_back(1); d_read = 1'b0; end
            if (o_i_resp) begin order_q.push_back(0); i_read = 1'b0; end
            if (busy) begin
                if (cnt == lat - 1) begin mem_resp = 1'b1; cnt = 0; end
                else begin mem_resp = 1'b0; cnt++; end
            end else begin
                mem_resp = 1'b0;
            end
            if (order_q.size() == need) break;
        end
        mem_resp = 1'b0;
        i_read   = 1'b0;
        d_read   = 1'b0;
        chk("served_count", order_q.size(), need);
        tick();
        tick();
    endtask

    task automatic order_rounds(input int exp_r3_first);
        cur = 100;
        run_order(1'b1, 1'b1, 2);
        chk("tie1_first", ord_at(0), 1);
        chk("tie1_second", ord_at(1), 0);
        chk("b2b_spacing", (rise_q.size() > 1) ? rise_q[1] - rise_q[0] : -1, 4);
        cur = 101;
        run_order(1'b0, 1'b1, 3);
        chk("d_only", ord_at(0), 1);
        cur = 102;
        run_order(1'b1, 1'b1, 1);
        chk("tie3_first", ord_at(0), exp_r3_first);
        chk("tie3_second", ord_at(1), 1 - exp_r3_first);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_1234, '0,   4, L_A5, 1'b1, 1'b0, 32'h0000_1220, L_A5, '0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h8000_003F, L_WB, 3, L_77, 1'b0, 1'b1, 32'h8000_0020, L_A5, '0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0000_0040, '0,   2, L_5A, 1'b1, 1'b0, 32'h0000_0040, L_A5, L_5A};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h0000_00FF, L_3C, 1, L_FF, 1'b0, 1'b1, 32'h0000_00E0, L_A5, L_5A};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, '0,   1, L_0F, 1'b1, 1'b0, 32'hFFFF_FFE0, L_0F, L_5A};

        sel = 1'b0;
        rst = 1'b1;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; mem_resp = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        do_reset();

        cur = 0;
        chk("rst_mem_read", o_mem_read, 1'b0);
        chk("rst_mem_write", o_mem_write, 1'b0);
        chk("rst_mem_addr", o_mem_addr, '0);
        chk("rst_mem_wdata", o_mem_wdata, '0);
        chk("rst_resp", {o_i_resp, o_d_resp}, 2'b00);
        chk("rst_rdata", {o_i_rdata, o_d_rdata}, '0);

        for (int k = 0; k < 5; k++) begin
            cur = 10 + k;
            run_vec(vecs[k]);
        end

        // mem_resp while idle is ignored
        cur = 20;
        mem_resp  = 1'b1;
        mem_rdata = L_FF;
        tick();
        mem_resp = 1'b0;
        chk("idle_resp", {o_i_resp, o_d_resp}, 2'b00);
        chk("idle_i_rdata", o_i_rdata, L_0F);
        chk("idle_d_rdata", o_d_rdata, L_5A);
        chk("idle_strobe", {o_mem_read, o_mem_write}, 2'b00);
        tick();

        // reset two cycles into a MEM_I transaction
        cur = 30;
        i_read = 1'b1;
        i_addr = 32'h0000_4444;
        tick();
        chk("abort_grant", o_mem_read, 1'b1);
        tick();
        tick();
        rst    = 1'b1;
        i_read = 1'b0;
        tick();
        rst = 1'b0;
        chk("abort_strobe", {o_mem_read, o_mem_write}, 2'b00);
        chk("abort_addr", o_mem_addr, '0);
        chk("abort_resp", {o_i_resp, o_d_resp}, 2'b00);
        chk("abort_rdata", {o_i_rdata, o_d_rdata}, '0);
        mem_resp  = 1'b1;
        mem_rdata = L_FF;
        tick();
        mem_resp = 1'b0;
        chk("late_resp", {o_i_resp, o_d_resp}, 2'b00);
        chk("late_i_rdata", o_i_rdata, '0);
        d_read = 1'b1;
        d_addr = 32'h0000_0105;
        tick();
        chk("post_rst_read", o_mem_read, 1'b1);
        chk("post_rst_addr", o_mem_addr, 32'h0000_0100);
        mem_resp  = 1'b1;
        mem_rdata = L_C3;
        tick();
        mem_resp = 1'b0;
        chk("post_rst_d_resp", o_d_resp, 1'b1);
        chk("post_rst_d_rdata", o_d_rdata, L_C3);
        d_read = 1'b0;
        tick();
        tick();

        // round-robin instance: tie after a D-only grant goes to I
        do_reset();
        order_rounds(0);

        // fixed D priority instance
        sel = 1'b1;
        do_reset();
        order_rounds(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
